// File: rtl/charattr_row_loader_pkg.sv
// Shared types and sizes for the character/attribute row buffer and its loader.
package charattr_pkg;

    localparam int CHARATTR_WIDTH = 32;
    localparam int ROW_BUF_DEPTH  = 88;
    localparam int ROW_BUF_AWIDTH = 7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FIN
    } state_t;

endpackage

// File: rtl/charattr_row_loader_if.sv
// Burst-read port between the row loader (master) and video memory (slave).
interface charattr_row_loader_if #(
    parameter int ADDR_WIDTH = 24
);

    logic                                    mem_request;
    logic [ADDR_WIDTH-1:0]                   mem_address;
    logic                                    mem_ack;
    logic [charattr_pkg::CHARATTR_WIDTH-1:0] mem_data;
    logic                                    mem_data_valid;

    modport master (
        output mem_request,
        output mem_address,
        input  mem_ack,
        input  mem_data,
        input  mem_data_valid
    );

    modport slave (
        input  mem_request,
        input  mem_address,
        output mem_ack,
        output mem_data,
        output mem_data_valid
    );

endinterface

// File: rtl/charattr_row_loader.sv
// Fetches one text row in BURST-word reads and writes it into the row buffer.
// Each returned word is written exactly one cycle after its valid; requests hold until acked.
module charattr_row_loader
    import charattr_pkg::*;
#(
    parameter int COLUMNS    = 80,
    parameter int BURST      = 8,
    parameter int ADDR_WIDTH = 24,
    parameter int ROW_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      row_start,
    input  logic [ROW_WIDTH-1:0]      row_number,
    input  logic [ADDR_WIDTH-1:0]     base_address,
    charattr_row_loader_if.master     mem,
    output logic                      wr_en,
    output logic [ROW_BUF_AWIDTH-1:0] wr_addr,
    output logic [CHARATTR_WIDTH-1:0] wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int                        BEAT_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(BURST - 1);
    localparam logic [ROW_BUF_AWIDTH-1:0] COL_LAST  = ROW_BUF_AWIDTH'(COLUMNS - 1);

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     row_addr;
    logic [ROW_BUF_AWIDTH-1:0] col;
    logic [BEAT_W-1:0]         beat;
    logic [ADDR_WIDTH-1:0]     start_addr;

    // Constant multiplier: reduces to shift-add, wraps modulo 2^ADDR_WIDTH.
    assign start_addr = base_address + ADDR_WIDTH'(row_number) * ADDR_WIDTH'(COLUMNS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            row_addr        <= '0;
            col             <= '0;
            beat            <= '0;
            mem.mem_request <= 1'b0;
            mem.mem_address <= '0;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            done    <= 1'b0;
            overrun <= row_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (row_start) begin
                        row_addr        <= start_addr;
                        col             <= '0;
                        beat            <= '0;
                        mem.mem_request <= 1'b1;
                        mem.mem_address <= start_addr;
                        busy            <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        mem.mem_request <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_data_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= col;
                        wr_data <= mem.mem_data;
                        col     <= col + 1'b1;
                        beat    <= beat + 1'b1;
                        if (col == COL_LAST) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else if (beat == BEAT_LAST) begin
                            // Next burst starts where this one ended.
                            beat            <= '0;
                            mem.mem_request <= 1'b1;
                            mem.mem_address <= row_addr + ADDR_WIDTH'(col) + ADDR_WIDTH'(1);
                            state           <= REQ;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_charattr_row_loader.sv
// Randomized bench: memory responder plus a row-level reference model checked every cycle.
module tb_charattr_row_loader;
    import charattr_pkg::*;

    localparam int COLUMNS = 80;
    localparam int BURST   = 8;
    localparam int AW      = 24;
    localparam int RW      = 6;

    logic                      clk          = 1'b0;
    logic                      reset        = 1'b1;
    logic                      row_start    = 1'b0;
    logic [RW-1:0]             row_number   = '0;
    logic [AW-1:0]             base_address = '0;
    logic                      wr_en;
    logic [ROW_BUF_AWIDTH-1:0] wr_addr;
    logic [CHARATTR_WIDTH-1:0] wr_data;
    logic                      busy;
    logic                      done;
    logic                      overrun;

    charattr_row_loader_if #(.ADDR_WIDTH(AW)) mem ();

    charattr_row_loader #(
        .COLUMNS(COLUMNS), .BURST(BURST), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)
    ) dut (
        .clk(clk), .reset(reset), .row_start(row_start), .row_number(row_number),
        .base_address(base_address), .mem(mem), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    logic [7:0] seed = 8'h3C;

    function automatic logic [31:0] word(input logic [AW-1:0] a, input logic [7:0] s);
        return {a[7:0] ^ s, a};
    endfunction

    // Memory responder
    int            ack_delay = 0;
    int            gap       = 0;
    bit            rand_gap  = 1'b0;
    int            stray     = 0;
    int            beats     = 0;
    int            wcnt      = 0;
    int            gcnt      = 0;
    logic [AW-1:0] paddr     = '0;

    initial begin
        mem.mem_ack        = 1'b0;
        mem.mem_data_valid = 1'b0;
        mem.mem_data       = '0;
        forever begin
            @(negedge clk);
            mem.mem_ack        = 1'b0;
            mem.mem_data_valid = 1'b0;
            mem.mem_data       = $urandom;
            if (stray > 0) begin
                mem.mem_data_valid = 1'b1;
                stray--;
            end else if (beats > 0) begin
                if (gcnt == 0) begin
                    mem.mem_data_valid = 1'b1;
                    mem.mem_data       = word(paddr, seed);
                    paddr++;
                    beats--;
                    gcnt = rand_gap ? $urandom_range(gap, 0) : gap;
                end else begin
                    gcnt--;
                end
            end else if (mem.mem_request && !reset) begin
                if (wcnt >= ack_delay) begin
                    mem.mem_ack = 1'b1;
                    paddr       = mem.mem_address;
                    beats       = BURST;
                    wcnt        = 0;
                    gcnt        = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Reference model: row accept/overrun rules, column-ordered writes, burst address sequence.
    bit            busy_p = 1'b0, fin_p = 1'b0, req_p = 1'b0;
    bit            acc, ov, wr, dn, bexp;
    logic [AW-1:0] addr_p = '0, row_addr = '0, first_ack = '0, last_ack = '0;
    logic [6:0]    done_waddr = '0, first_waddr = '0;
    bit            got_first = 1'b0;
    int            col = 0, nacks = 0, n_writes = 0, n_over = 0, n_done = 0, req_hi = 0, n_wr_total = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (wr_en) n_wr_total++;
        if (reset) begin
            chk("reset_outputs", {wr_en, wr_addr, wr_data, busy, done, overrun,
                                  mem.mem_request, mem.mem_address}, '0);
            busy_p = 1'b0; fin_p = 1'b0; req_p = 1'b0; col = 0;
        end else begin
            acc = row_start && !busy_p;
            ov  = row_start && busy_p;
            if (acc) begin
                row_addr  = AW'((int'(base_address) + int'(row_number) * COLUMNS) % (1 << AW));
                col       = 0;
                nacks     = 0;
                n_writes  = 0;
                req_hi    = 0;
                got_first = 1'b0;
            end
            wr = mem.mem_data_valid && busy_p && (col < COLUMNS);
            chk("wr_en", wr_en, wr);
            if (wr) begin
                chk("wr_addr", wr_addr, col);
                chk("wr_data", wr_data, word(row_addr + AW'(col), seed));
                if (!got_first) begin first_waddr = wr_addr; got_first = 1'b1; end
                col++;
                n_writes++;
            end
            dn = wr && (col == COLUMNS);
            chk("done", done, dn);
            if (done) begin n_done++; done_waddr = wr_addr; end
            chk("overrun", overrun, ov);
            if (overrun) n_over++;
            bexp = acc || (busy_p && !fin_p);
            chk("busy", busy, bexp);
            if (acc) begin
                chk("req_first", {mem.mem_request, mem.mem_address}, {1'b1, row_addr});
            end else if (req_p) begin
                if (mem.mem_ack) begin
                    chk("ack_addr", addr_p, row_addr + AW'(BURST * nacks));
                    if (nacks == 0) first_ack = addr_p;
                    last_ack = addr_p;
                    nacks++;
                    chk("req_drop", mem.mem_request, 1'b0);
                end else begin
                    chk("req_hold", {mem.mem_request, mem.mem_address}, {1'b1, addr_p});
                end
            end else if (wr && (col % BURST == 0) && (col < COLUMNS)) begin
                chk("req_next", {mem.mem_request, mem.mem_address}, {1'b1, row_addr + AW'(col)});
            end else begin
                chk("req_idle", mem.mem_request, 1'b0);
            end
            if (mem.mem_request && nacks == 0) req_hi++;
            busy_p = bexp;
            fin_p  = dn;
        end
        req_p  = mem.mem_request;
        addr_p = mem.mem_address;
    end

    task automatic start_row(input logic [AW-1:0] b, input logic [RW-1:0] r);
        @(negedge clk);
        base_address = b;
        row_number   = r;
        row_start    = 1'b1;
        @(negedge clk);
        row_start = 1'b0;
    endtask

    task automatic wait_done_cnt(input string nm, input int target);
        int cyc = 0;
        while (n_done < target && cyc < 4000) begin @(negedge clk); cyc++; end
        chk(nm, n_done >= target, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_row(input string nm, input logic [AW-1:0] b, input logic [RW-1:0] r);
        int d0;
        d0 = n_done;
        start_row(b, r);
        wait_done_cnt(nm, d0 + 1);
    endtask

    initial begin
        int            d0, ov0, w0, cyc;
        logic [AW-1:0] b;
        logic [RW-1:0] r;

        repeat (3) @(negedge clk);
        chk("init_outputs", {wr_en, busy, done, overrun, mem.mem_request, mem.mem_address}, '0);
        reset = 1'b0;

        // Nominal row, 1-cycle acks, continuous data
        run_row("A_done", 24'h000100, 6'd2);
        chk("A_first_burst", first_ack, 24'h0001A0);
        chk("A_last_burst", last_ack, 24'h0001E8);
        chk("A_writes", n_writes, 80);
        chk("A_bursts", nacks, 10);
        chk("A_done_waddr", done_waddr, 7'd79);

        // Slow acks
        ack_delay = 5;
        seed = 8'($urandom);
        run_row("B_done", AW'($urandom), RW'($urandom));
        chk("B_req_hold_cycles", req_hi, 6);
        chk("B_bursts", nacks, 10);
        chk("B_writes", n_writes, 80);

        // One valid in three
        ack_delay = 1; gap = 2; rand_gap = 1'b0;
        run_row("C_done", AW'($urandom), RW'($urandom));
        chk("C_writes", n_writes, 80);

        // Overrun during the third burst
        ack_delay = 1; gap = 1; rand_gap = 1'b1;
        b = AW'($urandom); r = RW'($urandom);
        d0 = n_done;
        start_row(b, r);
        cyc = 0;
        while (nacks < 3 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("D_reach_burst3", nacks >= 3, 1'b1);
        ov0 = n_over;
        base_address = AW'($urandom); row_number = RW'($urandom); row_start = 1'b1;
        @(negedge clk);
        row_start = 1'b0;
        wait_done_cnt("D_done", d0 + 1);
        chk("D_overrun_count", n_over - ov0, 1);
        chk("D_writes", n_writes, 80);
        chk("D_last_burst", last_ack, b + AW'(r) * AW'(80) + AW'(72));

        // row_start in FIN is an overrun; in the following IDLE cycle it is accepted
        ack_delay = 0; gap = 0; rand_gap = 1'b0;
        start_row(AW'($urandom), RW'($urandom));
        cyc = 0;
        while (!done && cyc < 4000) begin @(negedge clk); cyc++; end
        chk("E_reach_fin", done, 1'b1);
        ov0 = n_over;
        row_start = 1'b1;
        @(negedge clk);
        chk("E_fin_overrun", overrun, 1'b1);
        d0 = n_done;
        row_number = RW'($urandom);
        @(negedge clk);
        row_start = 1'b0;
        chk("E_idle_accept", busy, 1'b1);
        wait_done_cnt("E_done2", d0 + 1);
        chk("E_overrun_count", n_over - ov0, 1);
        chk("E_writes", n_writes, 80);

        // Address wrap-around
        run_row("F_done", 24'hFFFFF0, 6'd1);
        chk("F_first_burst", first_ack, 24'h000040);

        // Reset mid-burst, then stray data
        gap = 1; rand_gap = 1'b1;
        start_row(AW'($urandom), RW'($urandom));
        cyc = 0;
        while (n_writes < 12 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("G_reach_mid", n_writes >= 12, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("G_reset_outputs", {wr_en, wr_addr, wr_data, busy, done, overrun,
                                mem.mem_request, mem.mem_address}, '0);
        reset = 1'b0;
        w0 = n_wr_total;
        stray = 4;
        repeat (10) @(negedge clk);
        chk("G_no_writes", n_wr_total - w0, 0);
        chk("G_idle_outputs", {wr_en, wr_addr, wr_data, busy, mem.mem_request}, '0);
        cyc = 0;
        while (beats > 0 && cyc < 200) begin @(negedge clk); cyc++; end

        // Fresh row after reset
        seed = 8'($urandom);
        run_row("H_done", AW'($urandom), RW'($urandom));
        chk("H_first_waddr", first_waddr, 7'd0);
        chk("H_writes", n_writes, 80);

        // Randomized rows
        for (int i = 0; i < 3; i++) begin
            ack_delay = $urandom_range(3, 0);
            gap       = $urandom_range(2, 0);
            rand_gap  = 1'b1;
            seed      = 8'($urandom);
            run_row("R_done", AW'($urandom), RW'($urandom));
            chk("R_writes", n_writes, 80);
            chk("R_bursts", nacks, 10);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
